// File: rtl/popcount_burst_arbiter_if.sv
// Bundle of requester-side and result-side signals for popcount_burst_arbiter.
// slave = the arbiter's view, master = the view of whoever drives requests
// and consumes results.
interface popcount_burst_arbiter_if #(
  parameter int WIDTH_I   = 8,
  parameter int NUM_REQ   = 3,
  parameter int MAX_BEATS = 16
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int ACC_W  = $clog2(WIDTH_I * MAX_BEATS + 1);

  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ*WIDTH_I-1:0] req_data_i;
  logic [NUM_REQ-1:0]         req_last_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic                       res_valid_o;
  logic                       res_ready_i;
  logic [ID_W-1:0]            res_id_o;
  logic [ACC_W-1:0]           res_ones_o;
  logic [ACC_W-1:0]           res_zeros_o;
  logic [BEAT_W-1:0]          res_beats_o;
  logic                       res_ovf_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, res_ready_i,
    output req_ready_o, res_valid_o, res_id_o, res_ones_o, res_zeros_o,
           res_beats_o, res_ovf_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_id_o, res_ones_o, res_zeros_o,
           res_beats_o, res_ovf_o
  );
endinterface

// File: rtl/popcount_burst_arbiter.sv
// popcount_burst_arbiter: round-robin arbiter that locks one requester per
// burst, popcounts every accepted beat through a single shared
// zeros_ones_count datapath and emits a tagged ones/zeros/beats result.
// Bursts that reach MAX_BEATS without a last beat are cut and flagged; the
// remaining beats of that requester compete again as a fresh burst.

// Combinational ones/zeros counter for one data word.
module zeros_ones_count #(
  parameter  int WIDTH_I = 8,
  localparam int CNT_W   = $clog2(WIDTH_I + 1)
) (
  input  logic [WIDTH_I-1:0] i_data,
  output logic [CNT_W-1:0]   o_ones,
  output logic [CNT_W-1:0]   o_zeros
);
  function automatic logic [CNT_W-1:0] f_popcount(input logic [WIDTH_I-1:0] d);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < WIDTH_I; k++) begin
      c = c + CNT_W'(d[k]);
    end
    return c;
  endfunction

  assign o_ones  = f_popcount(i_data);
  assign o_zeros = CNT_W'(WIDTH_I) - o_ones;
endmodule

module popcount_burst_arbiter #(
  parameter int WIDTH_I   = 8,
  parameter int NUM_REQ   = 3,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  popcount_burst_arbiter_if.slave  bus
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int ACC_W  = $clog2(WIDTH_I * MAX_BEATS + 1);
  localparam int CNT_W  = $clog2(WIDTH_I + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST  = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  // Lowest set index of a request vector (vector assumed non-zero when used).
  function automatic logic [ID_W-1:0] f_lowest(input logic [NUM_REQ-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (v[j]) r = ID_W'(j);
    end
    return r;
  endfunction

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_grant;
  logic [NUM_REQ-1:0]  r_ready;
  logic [ACC_W-1:0]    r_ones_acc;
  logic [ACC_W-1:0]    r_zeros_acc;
  logic [BEAT_W-1:0]   r_beats;
  logic                r_res_valid;
  logic [ID_W-1:0]     r_res_id;
  logic [ACC_W-1:0]    r_res_ones;
  logic [ACC_W-1:0]    r_res_zeros;
  logic [BEAT_W-1:0]   r_res_beats;
  logic                r_res_ovf;

  logic [NUM_REQ-1:0]  w_mask_hi;
  logic [NUM_REQ-1:0]  w_cand_hi;
  logic [ID_W-1:0]     w_next_grant;
  logic [NUM_REQ-1:0]  w_grant_onehot;
  logic                w_any_req;
  logic [WIDTH_I-1:0]  w_gdata;
  logic [CNT_W-1:0]    w_cnt_ones;
  logic [CNT_W-1:0]    w_cnt_zeros;
  logic                w_xfer;
  logic                w_last;
  logic [ACC_W-1:0]    w_ones_nxt;
  logic [ACC_W-1:0]    w_zeros_nxt;
  logic [BEAT_W-1:0]   w_beats_nxt;
  logic                w_burst_end;

  // Round-robin pick: first valid index strictly above the pointer, else wrap to the lowest valid.
  always_comb begin
    w_mask_hi = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_mask_hi[j] = (ID_W'(j) > r_ptr);
    end
    w_cand_hi      = bus.req_valid_i & w_mask_hi;
    w_any_req      = |bus.req_valid_i;
    w_next_grant   = (|w_cand_hi) ? f_lowest(w_cand_hi) : f_lowest(bus.req_valid_i);
    w_grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_next_grant;
  end

  // Granted-data mux; r_ready is one-hot on the grant during a burst and zero otherwise.
  always_comb begin
    w_gdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_gdata = w_gdata | (bus.req_data_i[j*WIDTH_I +: WIDTH_I] & {WIDTH_I{r_ready[j]}});
    end
  end

  zeros_ones_count #(.WIDTH_I(WIDTH_I)) u_count (
    .i_data  (w_gdata),
    .o_ones  (w_cnt_ones),
    .o_zeros (w_cnt_zeros)
  );

  assign w_xfer      = (r_state == S_BURST) && (|(bus.req_valid_i & r_ready));
  assign w_last      = |(bus.req_last_i & r_ready);
  assign w_ones_nxt  = r_ones_acc + ACC_W'(w_cnt_ones);
  assign w_zeros_nxt = r_zeros_acc + ACC_W'(w_cnt_zeros);
  assign w_beats_nxt = r_beats + BEAT_W'(1);
  assign w_burst_end = w_last || (w_beats_nxt == BEAT_W'(MAX_BEATS));

  // Arbitration / burst / result FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_grant     <= '0;
      r_ready     <= '0;
      r_ones_acc  <= '0;
      r_zeros_acc <= '0;
      r_beats     <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_ones  <= '0;
      r_res_zeros <= '0;
      r_res_beats <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant     <= w_next_grant;
            r_ready     <= w_grant_onehot;
            r_ones_acc  <= '0;
            r_zeros_acc <= '0;
            r_beats     <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_xfer) begin
            r_ones_acc  <= w_ones_nxt;
            r_zeros_acc <= w_zeros_nxt;
            r_beats     <= w_beats_nxt;
            if (w_burst_end) begin
              r_ready     <= '0;
              r_res_valid <= 1'b1;
              r_res_id    <= r_grant;
              r_res_ones  <= w_ones_nxt;
              r_res_zeros <= w_zeros_nxt;
              r_res_beats <= w_beats_nxt;
              r_res_ovf   <= ~w_last;
              r_state     <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (bus.res_ready_i) begin
            r_res_valid <= 1'b0;
            r_ptr       <= r_grant;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_ready     <= '0;
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.res_valid_o = r_res_valid;
  assign bus.res_id_o    = r_res_id;
  assign bus.res_ones_o  = r_res_ones;
  assign bus.res_zeros_o = r_res_zeros;
  assign bus.res_beats_o = r_res_beats;
  assign bus.res_ovf_o   = r_res_ovf;
endmodule

// File: tb/tb_popcount_burst_arbiter.sv
// Directed bench for popcount_burst_arbiter (WIDTH_I=8, NUM_REQ=3, MAX_BEATS=4).
// A small burst model computes expected results as beats are driven and pushes
// them to a scoreboard queue; results are popped and compared as they appear.
module tb_popcount_burst_arbiter;
  localparam int W  = 8;
  localparam int NR = 3;
  localparam int MB = 4;

  typedef struct {
    int id;
    int ones;
    int zeros;
    int beats;
    int ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   m_ones;
  int   m_beats;
  exp_t sb_q[$];

  popcount_burst_arbiter_if #(.WIDTH_I(W), .NUM_REQ(NR), .MAX_BEATS(MB)) bus ();

  popcount_burst_arbiter #(.WIDTH_I(W), .NUM_REQ(NR), .MAX_BEATS(MB)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // At most one ready bit may ever be high.
  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("ready_onehot0", 32'($onehot0(bus.req_ready_o)), 32'd1);
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.res_valid_o), 32'd0);
    chk({tag, "_id"},    32'(bus.res_id_o),    32'd0);
    chk({tag, "_ones"},  32'(bus.res_ones_o),  32'd0);
    chk({tag, "_zeros"}, 32'(bus.res_zeros_o), 32'd0);
    chk({tag, "_beats"}, 32'(bus.res_beats_o), 32'd0);
    chk({tag, "_ovf"},   32'(bus.res_ovf_o),   32'd0);
  endtask

  task automatic chk_res(input string tag, input exp_t e);
    chk({tag, "_id"},    32'(bus.res_id_o),    32'(e.id));
    chk({tag, "_ones"},  32'(bus.res_ones_o),  32'(e.ones));
    chk({tag, "_zeros"}, 32'(bus.res_zeros_o), 32'(e.zeros));
    chk({tag, "_beats"}, 32'(bus.res_beats_o), 32'(e.beats));
    chk({tag, "_ovf"},   32'(bus.res_ovf_o),   32'(e.ovf));
  endtask

  // Drive one beat on requester k and wait (bounded) for it to be accepted.
  task automatic send_beat(input int k, input logic [7:0] d, input logic last);
    int n;
    bus.req_valid_i[k]      = 1'b1;
    bus.req_data_i[k*W +: W] = d;
    bus.req_last_i[k]       = last;
    n = 0;
    while (bus.req_ready_o[k] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("beat_accept_wait", 32'(bus.req_ready_o[k]), 32'd1);
    if (bus.req_ready_o[k] === 1'b1) begin
      m_ones  += $countones(d);
      m_beats += 1;
      if (last || m_beats == MB) begin
        sb_q.push_back('{k, m_ones, m_beats * W - m_ones, m_beats, last ? 0 : 1});
        m_ones  = 0;
        m_beats = 0;
      end
      step();
    end
  endtask

  task automatic drop(input int k);
    bus.req_valid_i[k] = 1'b0;
    bus.req_last_i[k]  = 1'b0;
  endtask

  // Wait (bounded) for any grant and compare the ready vector.
  task automatic grant_wait(input string tag, input logic [2:0] exp_vec);
    int n;
    n = 0;
    while (bus.req_ready_o === 3'b000 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.req_ready_o), 32'(exp_vec));
  endtask

  // Wait (bounded) for a result, compare it with the scoreboard head and consume it.
  task automatic get_result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus.res_valid_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_res_valid"}, 32'(bus.res_valid_o), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (bus.res_valid_o === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_res(tag, e);
      step();
    end
  endtask

  initial begin
    int   rr_order[5];
    logic [7:0] rr_data[3];
    n_tests = 0;
    n_fail  = 0;
    m_ones  = 0;
    m_beats = 0;
    rr_order = '{0, 1, 2, 0, 1};
    rr_data  = '{8'h01, 8'h03, 8'h07};
    rst_n           = 1'b0;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    bus.res_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_outputs_zero("post_reset_idle");

    // 1. Single burst on req0
    send_beat(0, 8'hFF, 1'b0);
    send_beat(0, 8'h0F, 1'b0);
    send_beat(0, 8'h00, 1'b1);
    drop(0);
    chk("t1_latency", 32'(bus.res_valid_o), 32'd1);
    chk("t1_ready_in_result", 32'(bus.req_ready_o), 32'd0);
    get_result("t1");

    // 2. Round-robin from a fresh pointer
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < NR; k++) begin
      bus.req_valid_i[k]       = 1'b1;
      bus.req_last_i[k]        = 1'b1;
      bus.req_data_i[k*W +: W] = rr_data[k];
    end
    for (int i = 0; i < 5; i++) begin
      grant_wait("t2_grant_order", 3'b001 << rr_order[i]);
      send_beat(rr_order[i], rr_data[rr_order[i]], 1'b1);
      get_result("t2");
    end
    for (int k = 0; k < NR; k++) drop(k);

    // 3. Result backpressure (pointer now 1, req0 alone)
    bus.res_ready_i = 1'b0;
    send_beat(0, 8'hAA, 1'b0);
    send_beat(0, 8'h81, 1'b1);
    drop(0);
    bus.req_valid_i[2]       = 1'b1;
    bus.req_last_i[2]        = 1'b1;
    bus.req_data_i[2*W +: W] = 8'h00;
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", 32'(bus.res_valid_o), 32'd1);
      chk("t3_hold_ready", 32'(bus.req_ready_o), 32'd0);
      chk("t3_sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) chk_res("t3_hold", sb_q[0]);
      step();
    end
    bus.res_ready_i = 1'b1;
    get_result("t3");
    chk("t3_idle_valid", 32'(bus.res_valid_o), 32'd0);
    chk("t3_idle_ready", 32'(bus.req_ready_o), 32'd0);
    step();
    chk("t3_next_grant", 32'(bus.req_ready_o), 32'b100);
    send_beat(2, 8'h00, 1'b1);
    drop(2);
    get_result("t3b");

    // 4. Overflow split on req1
    for (int b = 0; b < 4; b++) send_beat(1, 8'h01, 1'b0);
    get_result("t4a");
    send_beat(1, 8'h01, 1'b1);
    drop(1);
    get_result("t4b");

    // 5. Gap hold: req2 wins over req0 from pointer 1
    bus.req_valid_i[0]       = 1'b1;
    bus.req_last_i[0]        = 1'b1;
    bus.req_data_i[0*W +: W] = 8'h5A;
    send_beat(2, 8'h33, 1'b0);
    drop(2);
    for (int c = 0; c < 3; c++) begin
      chk("t5_gap_grant", 32'(bus.req_ready_o), 32'b100);
      step();
    end
    send_beat(2, 8'hF0, 1'b0);
    send_beat(2, 8'h7F, 1'b1);
    drop(2);
    get_result("t5");
    send_beat(0, 8'h5A, 1'b1);
    drop(0);
    get_result("t5b");

    // 6. Reset mid-burst (pointer now 0, req1 would win without reset)
    send_beat(1, 8'hFF, 1'b0);
    send_beat(1, 8'hFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    drop(1);
    m_ones  = 0;
    m_beats = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t6_no_result", 32'(bus.res_valid_o), 32'd0);
    end
    bus.req_valid_i[0]       = 1'b1;
    bus.req_last_i[0]        = 1'b1;
    bus.req_data_i[0*W +: W] = 8'h0F;
    bus.req_valid_i[1]       = 1'b1;
    bus.req_last_i[1]        = 1'b1;
    bus.req_data_i[1*W +: W] = 8'h3C;
    grant_wait("t6_first_grant", 3'b001);
    send_beat(0, 8'h0F, 1'b1);
    drop(0);
    get_result("t6a");
    send_beat(1, 8'h3C, 1'b1);
    drop(1);
    get_result("t6b");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
